// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter: round-robin arbiter sharing two GPR write ports among NUM_REQ result sources.
module gpr_write_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter bit SINGLE_WRITE_PORT = 1'b0,
    parameter int SEL_W             = 5,
    parameter int DATA_W            = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*SEL_W-1:0]    req_sel,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [SEL_W-1:0]            wa_sel,
    output logic [DATA_W-1:0]           wa,
    output logic                        wa_wr,
    output logic [SEL_W-1:0]            wb_sel,
    output logic [DATA_W-1:0]           wb,
    output logic                        wb_wr,
    output logic                        busy
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_g0;
    logic [PTR_W-1:0]   w_g1;
    logic [PTR_W-1:0]   w_last;
    logic [PTR_W-1:0]   w_next_ptr;
    logic               w_g0_hit;
    logic               w_g1_hit;
    logic [SEL_W-1:0]   w_g0_sel;
    logic [NUM_REQ-1:0] w_g0_vec;
    logic [NUM_REQ-1:0] w_g1_vec;

    // Scan from the priority pointer; the second grant skips any source aimed at G0's register.
    always_comb begin
        w_g0_hit = 1'b0;
        w_g1_hit = 1'b0;
        w_g0     = '0;
        w_g1     = '0;
        w_idx    = '0;
        w_g0_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                if (!w_g0_hit) begin
                    w_g0_hit = 1'b1;
                    w_g0     = w_idx;
                    w_g0_sel = req_sel[w_idx*SEL_W +: SEL_W];
                end else if (!SINGLE_WRITE_PORT && !w_g1_hit && req_sel[w_idx*SEL_W +: SEL_W] != w_g0_sel) begin
                    w_g1_hit = 1'b1;
                    w_g1     = w_idx;
                end
            end
        end
    end

    assign w_g0_vec   = (w_g0_hit && !reset) ? NUM_REQ'(1) << w_g0 : '0;
    assign w_g1_vec   = (w_g1_hit && !reset) ? NUM_REQ'(1) << w_g1 : '0;
    assign req_ready  = w_g0_vec | w_g1_vec;
    assign busy       = !reset && |(req_valid & ~req_ready);
    assign w_last     = w_g1_hit ? w_g1 : w_g0;
    assign w_next_ptr = (int'(w_last) == NUM_REQ - 1) ? '0 : w_last + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            wa_wr    <= 1'b0;
            wb_wr    <= 1'b0;
            wa_sel   <= '0;
            wb_sel   <= '0;
            wa       <= '0;
            wb       <= '0;
        end else begin
            wa_wr <= w_g0_hit;
            wb_wr <= w_g1_hit;
            if (w_g0_hit) begin
                wa_sel   <= req_sel[w_g0*SEL_W +: SEL_W];
                wa       <= req_data[w_g0*DATA_W +: DATA_W];
                r_rr_ptr <= w_next_ptr;
            end
            if (w_g1_hit) begin
                wb_sel <= req_sel[w_g1*SEL_W +: SEL_W];
                wb     <= req_data[w_g1*DATA_W +: DATA_W];
            end
        end
    end

`ifndef SYNTHESIS
    a_ports_distinct: assert property (@(posedge clk) wa_wr && wb_wr |-> wa_sel != wb_sel);
    a_single_port:    assert property (@(posedge clk) SINGLE_WRITE_PORT |-> !wb_wr);
    a_ready_valid:    assert property (@(posedge clk) (req_ready & ~req_valid) == '0);
    a_onehot_grants:  assert property (@(posedge clk) $onehot0(w_g0_vec) && $onehot0(w_g1_vec));
`endif
endmodule

// File: tb/tb_gpr_write_arbiter.sv
// tb_gpr_write_arbiter: scoreboard bench with a queue-based grant model; a second instance covers single-port mode.
module tb_gpr_write_arbiter;
    localparam int NR = 4;
    localparam int SW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic          wa_wr;
        logic          wb_wr;
        logic [SW-1:0] wa_sel;
        logic [SW-1:0] wb_sel;
        logic [DW-1:0] wa;
        logic [DW-1:0] wb;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*SW-1:0] req_sel = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic [SW-1:0]    wa_sel, wb_sel;
    logic [DW-1:0]    wa, wb;
    logic             wa_wr, wb_wr, busy;

    logic             sp_reset = 1'b1;
    logic [NR-1:0]    sp_valid = '1;
    logic [NR*SW-1:0] sp_sel = {5'd4, 5'd3, 5'd2, 5'd1};
    logic [NR*DW-1:0] sp_data = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    logic [NR-1:0]    sp_ready;
    logic [SW-1:0]    sp_wa_sel, sp_wb_sel;
    logic [DW-1:0]    sp_wa, sp_wb;
    logic             sp_wa_wr, sp_wb_wr, sp_busy;
    bit               sp_done = 0;

    int               checks = 0;
    int               errors = 0;
    exp_t             q[$];
    exp_t             m_last = '0;
    int               m_ptr = 0;
    bit               v[NR];
    logic [SW-1:0]    s[NR];
    logic [DW-1:0]    d[NR];
    bit               pend[NR];
    int               gcount[NR];

    always #5 clk = ~clk;

    gpr_write_arbiter #(.NUM_REQ(NR), .SINGLE_WRITE_PORT(1'b0), .SEL_W(SW), .DATA_W(DW)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data),
        .req_ready(req_ready), .wa_sel(wa_sel), .wa(wa), .wa_wr(wa_wr),
        .wb_sel(wb_sel), .wb(wb), .wb_wr(wb_wr), .busy(busy)
    );

    gpr_write_arbiter #(.NUM_REQ(NR), .SINGLE_WRITE_PORT(1'b1), .SEL_W(SW), .DATA_W(DW)) u_sp (
        .clk(clk), .reset(sp_reset), .req_valid(sp_valid), .req_sel(sp_sel), .req_data(sp_data),
        .req_ready(sp_ready), .wa_sel(sp_wa_sel), .wa(sp_wa), .wa_wr(sp_wa_wr),
        .wb_sel(sp_wb_sel), .wb(sp_wb), .wb_wr(sp_wb_wr), .busy(sp_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests, predict the grants, and queue the write expected after the edge.
    task automatic cycle(input bit rst);
        int            order[$];
        int            g0;
        int            g1;
        logic [NR-1:0] er;
        bit            eb;
        @(negedge clk);
        reset = rst;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = v[i];
            req_sel[i*SW +: SW]  = s[i];
            req_data[i*DW +: DW] = d[i];
        end
        #1;
        g0 = -1;
        g1 = -1;
        er = '0;
        if (!rst)
            for (int k = 0; k < NR; k++)
                if (v[(m_ptr + k) % NR]) order.push_back((m_ptr + k) % NR);
        if (order.size() > 0) begin
            g0 = order.pop_front();
            foreach (order[j])
                if (g1 < 0 && s[order[j]] != s[g0]) g1 = order[j];
        end
        if (g0 >= 0) er[g0] = 1'b1;
        if (g1 >= 0) er[g1] = 1'b1;
        eb = 0;
        for (int i = 0; i < NR; i++)
            if (v[i] && !er[i] && !rst) eb = 1;
        check("req_ready", 64'(req_ready), 64'(er));
        check("busy", 64'(busy), 64'(eb));
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) gcount[i]++;
            pend[i] = v[i] && !er[i] && !rst;
        end
        if (rst) begin
            m_last = '0;
            m_ptr  = 0;
        end else begin
            m_last.wa_wr = (g0 >= 0);
            m_last.wb_wr = (g1 >= 0);
            if (g0 >= 0) begin
                m_last.wa_sel = s[g0];
                m_last.wa     = d[g0];
                m_ptr         = (g0 + 1) % NR;
            end
            if (g1 >= 0) begin
                m_last.wb_sel = s[g1];
                m_last.wb     = d[g1];
                m_ptr         = (g1 + 1) % NR;
            end
        end
        q.push_back(m_last);
    endtask

    task automatic clear();
        for (int i = 0; i < NR; i++) v[i] = 0;
    endtask

    task automatic put(input int i, input logic [SW-1:0] sel, input logic [DW-1:0] data);
        v[i] = 1;
        s[i] = sel;
        d[i] = data;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("wa_wr", 64'(wa_wr), 64'(e.wa_wr));
            check("wb_wr", 64'(wb_wr), 64'(e.wb_wr));
            check("wa_sel", 64'(wa_sel), 64'(e.wa_sel));
            check("wb_sel", 64'(wb_sel), 64'(e.wb_sel));
            check("wa", 64'(wa), 64'(e.wa));
            check("wb", 64'(wb), 64'(e.wb));
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        sp_reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("sp_ready", 64'(sp_ready), 64'(1) << (c % 4));
            check("sp_busy", 64'(sp_busy), 64'(1));
            @(posedge clk);
            #1;
            check("sp_wa_wr", 64'(sp_wa_wr), 64'(1));
            check("sp_wa_sel", 64'(sp_wa_sel), 64'(c % 4 + 1));
            check("sp_wb_wr", 64'(sp_wb_wr), 64'(0));
            @(negedge clk);
        end
        sp_done = 1;
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            v[i] = 0; s[i] = '0; d[i] = '0; pend[i] = 0; gcount[i] = 0;
        end
        cycle(1);
        cycle(1);
        clear(); put(1, 5'd7, 32'hDEADBEEF); cycle(0);
        clear(); put(3, 5'd1, $urandom); cycle(0);
        clear(); put(0, 5'd3, $urandom); put(2, 5'd4, $urandom); cycle(0);
        clear(); put(3, 5'd2, $urandom); cycle(0);
        clear(); put(0, 5'd5, $urandom); put(1, 5'd5, $urandom); put(3, 5'd9, $urandom); cycle(0);
        v[0] = 0; v[3] = 0; cycle(0);
        for (int i = 0; i < NR; i++) gcount[i] = 0;
        clear();
        for (int i = 0; i < NR; i++) put(i, SW'(10 + i), $urandom);
        repeat (8) cycle(0);
        for (int i = 0; i < NR; i++) check("fair_count", 64'(gcount[i]), 64'(4));
        clear(); put(3, 5'd1, $urandom); cycle(0);
        clear(); put(0, 5'd6, $urandom); put(1, 5'd8, $urandom); put(2, 5'd6, $urandom); cycle(0);
        v[0] = 0; v[1] = 0; cycle(1);
        put(0, 5'd6, $urandom); cycle(0);
        v[0] = 0; cycle(0);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    s[i] = ($urandom_range(0, 1) == 0) ? SW'($urandom_range(0, 3)) : SW'($urandom_range(0, 31));
                    d[i] = $urandom;
                end
            cycle($urandom_range(0, 59) == 0);
        end
        clear();
        cycle(0);
        cycle(0);
        @(posedge clk);
        #2;
        check("queue_drained", 64'(q.size()), 64'(0));
        wait (sp_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
